cpu7_icu_fetch: RTL and testbench
=================================

Name: cpu7_icu_fetch

Overview:
- Responder end of the IFU instruction-fetch request interface.
- Accepts one fetch request at a time from the IFU and returns the aligned 64-bit doubleword that contains the requested address.
- Each request is served from a single-entry doubleword line buffer (hit) or from a valid/ready memory read port (miss).
- Sits between the IFU and the instruction-side memory/bus bridge.

Parameters:
BUF_EN, 1, 1 = line buffer enabled; 0 = every request goes to memory (buffer never hits).

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
ifu_icu_req_ic1  input  1  IFU fetch request valid
ifu_icu_addr_ic1  input  32  fetch address; bits [2:0] ignored
icu_ifu_ack_ic1  output  1  request accepted this cycle (combinational)
ifu_icu_cancel  input  1  kill the outstanding request
icu_ifu_data_ic2  output  64  returned doubleword
icu_ifu_data_valid_ic2  output  1  data valid, one-cycle pulse
icu_inv  input  1  invalidate the line buffer
icu_mem_req  output  1  memory read request valid
icu_mem_addr  output  32  memory address, {addr[31:3],3'b0}
mem_icu_req_ready  input  1  memory accepts the request
mem_icu_rdata  input  64  memory read data
mem_icu_rvalid  input  1  memory read data valid

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Buffer valid, drop flag, tag and data registers all 0.
- States:
  - IDLE
  - HIT: buffered data is returned in this cycle.
  - MREQ: icu_mem_req is asserted, waiting for ready.
  - MWAIT: waiting for rvalid.
  - RESP: memory data is returned in this cycle.
- Acceptance:
  - ack = req & (state==IDLE) & ~ifu_icu_cancel.
  - No acceptance in any other state, so there is exactly one outstanding request.
  - On ack, latch addr[31:3].
- Hit check (evaluated at acceptance): BUF_EN & buf_vld & ~icu_inv & (buf_tag==addr[31:3]).
  - Hit: go to HIT.
  - Miss: go to MREQ.
- HIT:
  - data_ic2 = buf_data.
  - data_valid = 1 (one cycle after ack, latency 1).
  - Next state IDLE.
- MREQ:
  - icu_mem_req = 1 with icu_mem_addr stable.
  - Once asserted, icu_mem_req is held until mem_icu_req_ready, even if the request is cancelled.
  - On ready, go to MWAIT. rvalid is never sampled in MREQ (the memory returns data no earlier than the cycle after ready).
- MWAIT:
  - On mem_icu_rvalid, capture rdata into the output register and into the buffer.
  - Buffer update: buf_tag = latched tag; buf_vld = 1, unless icu_inv is asserted in the same cycle, in which case buf_vld = 0.
  - Next state RESP.
- RESP:
  - data_valid = ~drop.
  - Next state IDLE.
  - Miss latency: data_valid one cycle after rvalid.
- Cancel:
  - In MREQ or MWAIT, ifu_icu_cancel sets the drop flag.
  - The memory transaction still completes and still fills the buffer, but its data_valid is suppressed.
  - In HIT or RESP, cancel combinationally masks data_valid in that cycle.
  - In IDLE, cancel has no effect and blocks ack for that cycle.
  - drop clears on entering IDLE.
- icu_inv:
  - Clears buf_vld on the next edge.
  - Has priority over a same-cycle fill.
  - A request accepted in the same cycle as icu_inv is treated as a miss.
- data_ic2 holds its last value when data_valid = 0.
- Asynchronous reset mid-transaction:
  - Forces IDLE and drops icu_mem_req immediately.
  - The memory side is reset by the same resetn, so no stale response is expected.
- BUF_EN = 0:
  - buf_vld is never set.
  - HIT state is unreachable.

Test Plan:
- Cold fetch: req, addr=0x1C000004, IDLE → ack same cycle; icu_mem_req=1 with addr 0x1C000000; ready 1 cycle later, rvalid 3 cycles later with 0x0123456789ABCDEF → data_valid one cycle after rvalid with that data; state returns to IDLE.
- Buffer hit: after the cold fetch, req addr=0x1C000000 → ack; data_valid next cycle with 0x0123456789ABCDEF; icu_mem_req stays 0.
- Cancel during MWAIT: miss to 0x1C000010, cancel pulse in MWAIT → no data_valid; buffer still filled (a later req to 0x1C000010 hits); ack stays 0 until IDLE.
- Cancel during MREQ with ready delayed 4 cycles: icu_mem_req held until ready; response dropped; a new req acked only after RESP.
- Invalidate: icu_inv then req to the buffered address → miss path taken; icu_inv in the same cycle as rvalid leaves buf_vld = 0.
- Reset mid-MWAIT: resetn low → icu_mem_req, data_valid and ack all 0 immediately; the next request after reset misses.

Source files
------------

// File: rtl/cpu7_icu_fetch.sv
// Instruction-fetch responder: serves one IFU request at a time from a single
// doubleword line buffer or through a valid/ready memory read port.
module cpu7_icu_fetch #(
    parameter bit BUF_EN = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ifu_icu_req_ic1,
    input  logic [31:0] ifu_icu_addr_ic1,
    output logic        icu_ifu_ack_ic1,
    input  logic        ifu_icu_cancel,
    output logic [63:0] icu_ifu_data_ic2,
    output logic        icu_ifu_data_valid_ic2,
    input  logic        icu_inv,
    output logic        icu_mem_req,
    output logic [31:0] icu_mem_addr,
    input  logic        mem_icu_req_ready,
    input  logic [63:0] mem_icu_rdata,
    input  logic        mem_icu_rvalid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIT   = 3'd1,
        S_MREQ  = 3'd2,
        S_MWAIT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [28:0] r_tag;
    logic [28:0] r_buf_tag;
    logic [63:0] r_buf_data;
    logic [63:0] r_data;
    logic        r_buf_vld;
    logic        r_drop;
    logic        w_ack;
    logic        w_hit;
    logic        w_fill;
    logic        w_unused;

    // The line offset never matters: the whole doubleword is always returned.
    assign w_unused = &{1'b0, ifu_icu_addr_ic1[2:0]};

    // resetn gates ack so nothing is accepted while the block is held in reset.
    assign w_ack  = ifu_icu_req_ic1 & (r_state == S_IDLE) & ~ifu_icu_cancel & resetn;
    assign w_hit  = BUF_EN & r_buf_vld & ~icu_inv & (r_buf_tag == ifu_icu_addr_ic1[31:3]);
    assign w_fill = (r_state == S_MWAIT) & mem_icu_rvalid;

    assign icu_ifu_ack_ic1  = w_ack;
    assign icu_ifu_data_ic2 = r_data;
    assign icu_mem_addr     = {r_tag, 3'b000};

    always_comb begin
        w_next                 = r_state;
        icu_ifu_data_valid_ic2 = 1'b0;
        icu_mem_req            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ack) begin
                    w_next = w_hit ? S_HIT : S_MREQ;
                end
            end
            S_HIT: begin
                icu_ifu_data_valid_ic2 = ~ifu_icu_cancel;
                w_next                 = S_IDLE;
            end
            S_MREQ: begin
                icu_mem_req = 1'b1;
                if (mem_icu_req_ready) begin
                    w_next = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (mem_icu_rvalid) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                icu_ifu_data_valid_ic2 = ~r_drop & ~ifu_icu_cancel;
                w_next                 = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_drop    <= 1'b0;
            r_buf_vld <= 1'b0;
        end else begin
            r_state <= w_next;
            // A cancelled miss still runs to completion; only its response is dropped.
            if (w_next == S_IDLE) begin
                r_drop <= 1'b0;
            end else if (((r_state == S_MREQ) || (r_state == S_MWAIT)) && ifu_icu_cancel) begin
                r_drop <= 1'b1;
            end
            if (icu_inv) begin
                r_buf_vld <= 1'b0;
            end else if (w_fill) begin
                r_buf_vld <= BUF_EN;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tag      <= 29'd0;
            r_buf_tag  <= 29'd0;
            r_buf_data <= 64'd0;
            r_data     <= 64'd0;
        end else begin
            if (w_ack) begin
                r_tag <= ifu_icu_addr_ic1[31:3];
            end
            if (w_fill) begin
                r_buf_tag  <= r_tag;
                r_buf_data <= mem_icu_rdata;
                r_data     <= mem_icu_rdata;
            end else if (w_ack && w_hit) begin
                r_data <= r_buf_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu7_icu_fetch.sv
// Bench for cpu7_icu_fetch: directed scenarios plus randomized fetches checked
// against a transaction-level model of the single-entry line buffer.
module tb_cpu7_icu_fetch;

    localparam bit BUF_EN = 1'b1;

    logic        clock;
    logic        resetn;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        cancel;
    logic [63:0] data;
    logic        dvalid;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        ready;
    logic [63:0] rdata;
    logic        rvalid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the line buffer holds.
    bit          m_vld  = 1'b0;
    logic [28:0] m_tag  = '0;
    logic [63:0] m_data = '0;

    cpu7_icu_fetch #(.BUF_EN(BUF_EN)) dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .ifu_icu_req_ic1        (req),
        .ifu_icu_addr_ic1       (addr),
        .icu_ifu_ack_ic1        (ack),
        .ifu_icu_cancel         (cancel),
        .icu_ifu_data_ic2       (data),
        .icu_ifu_data_valid_ic2 (dvalid),
        .icu_inv                (inv),
        .icu_mem_req            (mem_req),
        .icu_mem_addr           (mem_addr),
        .mem_icu_req_ready      (ready),
        .mem_icu_rdata          (rdata),
        .mem_icu_rvalid         (rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One complete fetch starting in IDLE at posedge+1. cmode: 0 none,
    // 1 cancel in first MREQ cycle, 2 cancel in first MWAIT cycle, 3 cancel in output cycle.
    task automatic run_fetch(input logic [31:0] a, input int rdy_dly, input int rv_dly,
                             input int cmode, input bit inv_acc, input bit inv_fill,
                             input logic [63:0] rd);
        bit exp_hit;
        bit dropped;
        logic [63:0] exp_data;
        exp_hit = BUF_EN && m_vld && !inv_acc && (m_tag == a[31:3]);
        exp_data = m_data;
        req = 1'b1; addr = a; inv = inv_acc; cancel = 1'b0;
        @(negedge clock);
        n_vec++;
        if (ack !== 1'b1) begin
            n_err++; $display("FAIL accept_ack addr=%h got=%b want=1", a, ack);
        end
        @(posedge clock); #1;
        inv = 1'b0;
        if (inv_acc) m_vld = 1'b0;
        if (exp_hit) begin
            cancel = (cmode == 3);
            @(negedge clock);
            n_vec++;
            if (dvalid !== !cancel || mem_req !== 1'b0 || ack !== 1'b0) begin
                n_err++; $display("FAIL hit_ctrl addr=%h valid=%b memreq=%b ack=%b want valid=%b", a, dvalid, mem_req, ack, !cancel);
            end
            if (!cancel) begin
                n_vec++;
                if (data !== exp_data) begin
                    n_err++; $display("FAIL hit_data addr=%h got=%h want=%h", a, data, exp_data);
                end
            end
            @(posedge clock); #1;
            cancel = 1'b0;
        end else begin
            dropped = 1'b0;
            for (int k = 0; k <= rdy_dly; k++) begin
                ready = (k == rdy_dly);
                cancel = (cmode == 1 && k == 0);
                dropped |= cancel;
                @(negedge clock);
                n_vec++;
                if (mem_req !== 1'b1 || mem_addr !== {a[31:3], 3'b000} || dvalid !== 1'b0 || ack !== 1'b0) begin
                    n_err++; $display("FAIL mreq cyc=%0d memreq=%b maddr=%h valid=%b ack=%b want 1/%h/0/0", k, mem_req, mem_addr, dvalid, ack, {a[31:3], 3'b000});
                end
                @(posedge clock); #1;
            end
            ready = 1'b0; cancel = 1'b0;
            for (int j = 1; j <= rv_dly; j++) begin
                rvalid = (j == rv_dly);
                rdata = rvalid ? rd : {$urandom, $urandom};
                cancel = (cmode == 2 && j == 1);
                inv = inv_fill && (j == rv_dly);
                dropped |= cancel;
                @(negedge clock);
                n_vec++;
                if (mem_req !== 1'b0 || dvalid !== 1'b0 || ack !== 1'b0) begin
                    n_err++; $display("FAIL mwait cyc=%0d memreq=%b valid=%b ack=%b want 0/0/0", j, mem_req, dvalid, ack);
                end
                @(posedge clock); #1;
            end
            rvalid = 1'b0; inv = 1'b0;
            cancel = (cmode == 3);
            m_tag = a[31:3]; m_data = rd; m_vld = BUF_EN && !inv_fill;
            @(negedge clock);
            n_vec++;
            if (dvalid !== !(dropped || cancel) || data !== rd || ack !== 1'b0 || mem_req !== 1'b0) begin
                n_err++; $display("FAIL resp addr=%h valid=%b data=%h ack=%b want valid=%b data=%h", a, dvalid, data, ack, !(dropped || cancel), rd);
            end
            @(posedge clock); #1;
            cancel = 1'b0;
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b1; addr = 32'h1C00_0004; cancel = 1'b0;
        inv = 1'b0; ready = 1'b0; rdata = '0; rvalid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if (ack !== 1'b0 || dvalid !== 1'b0 || mem_req !== 1'b0 || data !== 64'd0 || mem_addr !== 32'd0) begin
            n_err++; $display("FAIL reset_outputs ack=%b valid=%b memreq=%b data=%h maddr=%h want all 0", ack, dvalid, mem_req, data, mem_addr);
        end
        req = 1'b0;
        resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_cold_fetch();
        run_fetch(32'h1C00_0004, 0, 3, 0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_hit();
        run_fetch(32'h1C00_0000, 0, 1, 0, 1'b0, 1'b0, 64'h0);
        run_fetch(32'h1C00_0007, 0, 1, 3, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_cancel_idle();
        req = 1'b1; addr = 32'h1C00_0000; cancel = 1'b1;
        @(negedge clock);
        n_vec++;
        if (ack !== 1'b0) begin
            n_err++; $display("FAIL idle_cancel_ack got=%b want=0", ack);
        end
        @(posedge clock); #1;
        req = 1'b0; cancel = 1'b0;
        run_fetch(32'h1C00_0000, 0, 1, 0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_cancel_mwait();
        run_fetch(32'h1C00_0010, 1, 3, 2, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
        run_fetch(32'h1C00_0010, 0, 1, 0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_cancel_mreq();
        run_fetch(32'h1C00_0020, 4, 2, 1, 1'b0, 1'b0, 64'h1111_2222_3333_4444);
        run_fetch(32'h1C00_0030, 0, 1, 0, 1'b0, 1'b0, 64'h5555_6666_7777_8888);
    endtask

    task automatic test_invalidate();
        run_fetch(32'h2000_0040, 0, 1, 0, 1'b0, 1'b0, 64'hA5A5_0000_5A5A_FFFF);
        inv = 1'b1;
        @(posedge clock); #1;
        inv = 1'b0; m_vld = 1'b0;
        run_fetch(32'h2000_0040, 0, 2, 0, 1'b0, 1'b0, 64'hA5A5_0000_5A5A_1111);
        run_fetch(32'h2000_0040, 1, 1, 0, 1'b1, 1'b0, 64'hA5A5_0000_5A5A_2222);
        run_fetch(32'h2000_0048, 0, 2, 0, 1'b0, 1'b1, 64'hA5A5_0000_5A5A_3333);
        run_fetch(32'h2000_0048, 0, 1, 0, 1'b0, 1'b0, 64'hA5A5_0000_5A5A_4444);
    endtask

    task automatic test_reset_mid();
        run_fetch(32'h3000_0000, 0, 1, 0, 1'b0, 1'b0, 64'h3333_0000_3333_0000);
        // Reset while the memory request is pending.
        req = 1'b1; addr = 32'h3000_0100;
        @(posedge clock); #1;
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || ack !== 1'b0 || dvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_in_mreq memreq=%b ack=%b valid=%b want 0/0/0", mem_req, ack, dvalid);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        // Reset while waiting for read data.
        @(negedge clock);
        @(posedge clock); #1;
        ready = 1'b1;
        @(posedge clock); #1;
        ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || ack !== 1'b0 || dvalid !== 1'b0 || data !== 64'd0) begin
            n_err++; $display("FAIL reset_in_mwait memreq=%b ack=%b valid=%b data=%h want 0", mem_req, ack, dvalid, data);
        end
        @(posedge clock); #1;
        req = 1'b0; resetn = 1'b1; m_vld = 1'b0;
        run_fetch(32'h3000_0000, 0, 1, 0, 1'b0, 1'b0, 64'h3333_0000_3333_9999);
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        pool[0] = 32'h1C00_0000; pool[1] = 32'h1C00_0008;
        pool[2] = 32'h8000_1F00; pool[3] = 32'hFFFF_FFF8;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int cm;
            a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 7));
            cm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            case ($urandom_range(0, 7))
                0: begin
                    req = 1'b1; addr = a; cancel = 1'b1;
                    @(negedge clock);
                    n_vec++;
                    if (ack !== 1'b0) begin
                        n_err++; $display("FAIL rand_idle_cancel got=%b want=0", ack);
                    end
                    @(posedge clock); #1;
                    req = 1'b0; cancel = 1'b0;
                end
                1: begin
                    inv = 1'b1;
                    @(posedge clock); #1;
                    inv = 1'b0; m_vld = 1'b0;
                end
                default: ;
            endcase
            run_fetch(a, $urandom_range(0, 3), $urandom_range(1, 4), cm,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      {$urandom, $urandom});
        end
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_hit();
        test_cancel_idle();
        test_cancel_mwait();
        test_cancel_mreq();
        test_invalidate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
